// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_stage
//  Description : EX->MEM pipeline register with a 2-entry skid buffer.
//                Also keeps the architectural c/z/v flags and the HI register.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 4,
    parameter int REG_W   = 5,
    parameter int MUL_SEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_out0,
    input  logic [DATA_W-1:0] in_out1,
    input  logic [2:0]        in_flags,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_wb_en,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_out0,
    output logic [DATA_W-1:0] out_out1,
    output logic [2:0]        out_flags,
    output logic [SEL_W-1:0]  out_sel,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_wb_en,
    output logic [2:0]        status_flags,
    output logic [DATA_W-1:0] hi_reg
);

    localparam int PAY_W = 2 * DATA_W + 3 + SEL_W + REG_W + 1;

    logic              m_valid_q, m_valid_d;
    logic              s_valid_q, s_valid_d;
    logic [PAY_W-1:0]  m_pay_q,   m_pay_d;
    logic [PAY_W-1:0]  s_pay_q,   s_pay_d;
    logic [2:0]        status_q,  status_d;
    logic [DATA_W-1:0] hi_q,      hi_d;

    logic              w_accept;
    logic              w_retire;
    logic [PAY_W-1:0]  w_in_pay;

    assign w_in_pay = {in_out0, in_out1, in_flags, in_sel, in_rd, in_wb_en};

    // Flush drops the same-cycle input even though in_ready may be high.
    assign w_accept = in_valid & ~s_valid_q & ~flush;
    assign w_retire = m_valid_q & out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_pay_d   = m_pay_q;
        s_pay_d   = s_pay_q;
        status_d  = status_q;
        hi_d      = hi_q;

        if (!m_valid_q || w_retire) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                s_valid_d = 1'b0;
                if (!flush) begin
                    m_pay_d = s_pay_q;
                end
            end else if (w_accept) begin
                m_valid_d = 1'b1;
                m_pay_d   = w_in_pay;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            s_valid_d = 1'b1;
            s_pay_d   = w_in_pay;
        end

        // A retire in the flush cycle still updates the architectural state.
        if (w_retire) begin
            status_d = out_flags;
            if (out_sel == SEL_W'(MUL_SEL)) begin
                hi_d = out_out1;
            end
        end

        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_pay_q   <= '0;
            s_pay_q   <= '0;
            status_q  <= 3'b000;
            hi_q      <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_pay_q   <= m_pay_d;
            s_pay_q   <= s_pay_d;
            status_q  <= status_d;
            hi_q      <= hi_d;
        end
    end

    assign {out_out0, out_out1, out_flags, out_sel, out_rd, out_wb_en} = m_pay_q;
    assign out_valid    = m_valid_q;
    assign in_ready     = ~s_valid_q;
    assign status_flags = status_q;
    assign hi_reg       = hi_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_stage
//  Description : Scoreboard bench for ex_mem_stage with directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

    typedef struct packed {
        logic [31:0] o0;
        logic [31:0] o1;
        logic [2:0]  f;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        wb;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_out0;
    logic [31:0] in_out1;
    logic [2:0]  in_flags;
    logic [3:0]  in_sel;
    logic [4:0]  in_rd;
    logic        in_wb_en;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_out0;
    logic [31:0] out_out1;
    logic [2:0]  out_flags;
    logic [3:0]  out_sel;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic [2:0]  status_flags;
    logic [31:0] hi_reg;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    ent_t sb_q[$];
    logic [2:0]  exp_status;
    logic [31:0] exp_hi;

    ex_mem_stage #(
        .DATA_W  (32),
        .SEL_W   (4),
        .REG_W   (5),
        .MUL_SEL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_out0      (in_out0),
        .in_out1      (in_out1),
        .in_flags     (in_flags),
        .in_sel       (in_sel),
        .in_rd        (in_rd),
        .in_wb_en     (in_wb_en),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_out0     (out_out0),
        .out_out1     (out_out1),
        .out_flags    (out_flags),
        .out_sel      (out_sel),
        .out_rd       (out_rd),
        .out_wb_en    (out_wb_en),
        .status_flags (status_flags),
        .hi_reg       (hi_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor at the falling edge: state reflects the previous rising edge,
    // inputs are stable for the next one.
    always @(negedge clk) begin
        if (mon_en) begin
            ent_t e;
            chk("sb_out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
            chk("sb_in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
            chk("sb_status", 64'(status_flags), 64'(exp_status));
            chk("sb_hi", 64'(hi_reg), 64'(exp_hi));
            if (rst) begin
                sb_q.delete();
                exp_status = 3'b000;
                exp_hi     = 32'h0;
            end else begin
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_out", 64'(1), 64'(0));
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_out0", 64'(out_out0), 64'(e.o0));
                        chk("sb_out1", 64'(out_out1), 64'(e.o1));
                        chk("sb_flags", 64'(out_flags), 64'(e.f));
                        chk("sb_sel", 64'(out_sel), 64'(e.sel));
                        chk("sb_rd", 64'(out_rd), 64'(e.rd));
                        chk("sb_wb", 64'(out_wb_en), 64'(e.wb));
                        exp_status = e.f;
                        if (e.sel == 4'd2) exp_hi = e.o1;
                    end
                end
                if (in_valid && in_ready && !flush) begin
                    e = '{o0: in_out0, o1: in_out1, f: in_flags, sel: in_sel, rd: in_rd, wb: in_wb_en};
                    sb_q.push_back(e);
                end
                if (flush) sb_q.delete();
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] o0, input logic [31:0] o1, input logic [2:0] f,
                        input logic [3:0] sel, input logic [4:0] rd);
        in_valid = 1'b1;
        in_out0  = o0;
        in_out1  = o1;
        in_flags = f;
        in_sel   = sel;
        in_rd    = rd;
        in_wb_en = rd[0];
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_out0 = '0; in_out1 = '0; in_flags = '0;
        in_sel = '0; in_rd = '0; in_wb_en = 1'b0; flush = 1'b0; out_ready = 1'b0;
        exp_status = 3'b000; exp_hi = 32'h0;
        cyc();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_status", 64'(status_flags), 64'(0));
        chk("rst_hi", 64'(hi_reg), 64'(0));
        chk("rst_out0", 64'(out_out0), 64'(0));
        rst = 1'b0;
        mon_en = 1'b1;

        // Streaming: one-cycle latency, full throughput
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(32'(3 + 2 * i), 32'h0, 3'b000, 4'd0, 5'(i + 1));
            chk("stream_out0", 64'(out_out0), 64'(3 + 2 * i));
            chk("stream_in_ready", 64'(in_ready), 64'(1));
        end
        cyc();
        chk("stream_idle", 64'(out_valid), 64'(0));

        // Backpressure fills the skid entry
        out_ready = 1'b0;
        push(32'd1, 32'h0, 3'b000, 4'd0, 5'd6);
        chk("bp_ready1", 64'(in_ready), 64'(1));
        push(32'd2, 32'h0, 3'b000, 4'd0, 5'd7);
        chk("bp_ready2", 64'(in_ready), 64'(0));
        chk("bp_hold", 64'(out_out0), 64'(1));
        out_ready = 1'b1;
        cyc();
        chk("bp_second", 64'(out_out0), 64'(2));
        chk("bp_ready3", 64'(in_ready), 64'(1));
        cyc();

        // MUL retire writes HI; a following ADD leaves it
        push(32'h0, 32'h1, 3'b000, 4'd2, 5'd8);
        push(32'd4, 32'hdead, 3'b000, 4'd0, 5'd9);
        chk("mul_hi", 64'(hi_reg), 64'(1));
        cyc();
        chk("add_keeps_hi", 64'(hi_reg), 64'(1));

        // Flags from SUB then EQ
        push(32'hffff_ffff, 32'h0, 3'b100, 4'd1, 5'd10);
        push(32'h1, 32'h0, 3'b010, 4'd3, 5'd11);
        chk("flags_sub", 64'(status_flags), 64'(3'b100));
        cyc();
        chk("flags_eq", 64'(status_flags), 64'(3'b010));

        // Flush with both entries full while the main one retires
        out_ready = 1'b0;
        push(32'ha, 32'h55, 3'b001, 4'd2, 5'd12);
        push(32'hb, 32'h77, 3'b111, 4'd2, 5'd13);
        chk("flush_full", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        flush = 1'b1;
        push(32'hc, 32'h99, 3'b110, 4'd2, 5'd14);
        flush = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_status", 64'(status_flags), 64'(3'b001));
        chk("flush_hi", 64'(hi_reg), 64'(32'h55));
        cyc();

        // Reset in the middle of a held transfer
        out_ready = 1'b0;
        push(32'h33, 32'h0, 3'b011, 4'd0, 5'd15);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_hi", 64'(hi_reg), 64'(0));
        out_ready = 1'b1;
        cyc();
        cyc();
        chk("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
